// File: rtl/aes_cipher_ks.sv
// aes_cipher_ks: iterative AES encryption core, one round per clock.
// The key schedule is computed on the fly and KEY_BITS selects AES-128 or AES-256.
// Plaintext and ciphertext both use valid/ready handshakes, and the output side supports backpressure.
// Optional feature: define AES_CIPHER_ABORT_EN to add the abort input.
module aes_cipher_ks #(
    parameter int unsigned KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_valid,
    input  logic [KEY_BITS-1:0] key,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        text_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        text_out,
    output logic                busy,
`ifdef AES_CIPHER_ABORT_EN
    input  logic                abort,
`endif
    output logic [3:0]          rnd
);

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_cipher_ks: KEY_BITS must be 128 or 256");
    end

    localparam int unsigned NR      = (KEY_BITS == 256) ? 14 : 10;
    localparam logic [3:0]  LastRnd = 4'(NR);

    // Forward S-box, entry 0 in the MSBs.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] aes_sbox(input logic [7:0] b);
        return SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {aes_sbox(w[31:24]), aes_sbox(w[23:16]), aes_sbox(w[15:8]), aes_sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    typedef enum logic [1:0] {StIdle, StRound, StHold} state_e;

    state_e              state_q, state_d;
    logic [127:0]        st_q, st_d;
    logic [KEY_BITS-1:0] kw_q, kw_d;
    logic [KEY_BITS-1:0] key_q, key_d;
    logic [7:0]          rcon_q, rcon_d;
    logic [3:0]          rnd_q, rnd_d;
    logic [127:0]        text_out_q, text_out_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;

    logic [127:0]        sb_shift, mixed, rk, ks_new;
    logic [31:0]         ks_t;
    logic [KEY_BITS-1:0] kw_next;
    logic [7:0]          rcon_next;

    // SubBytes + ShiftRows, then MixColumns on the shifted state.
    always_comb begin
        sb_shift = '0;
        mixed    = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sb_shift[127 - 8 * (4 * c + r) -: 8] =
                    aes_sbox(st_q[127 - 8 * (4 * ((c + r) % 4) + r) -: 8]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            mixed[127 - 32 * c -: 32] = mix_col(sb_shift[127 - 32 * c -: 32]);
        end
    end

    if (KEY_BITS == 256) begin : g_ks256
        // Window holds the 8 newest words; round 1 uses the second key half directly.
        always_comb begin
            ks_t = rnd_q[0] ? sub_word(kw_q[31:0])
                            : sub_word({kw_q[23:0], kw_q[31:24]}) ^ {rcon_q, 24'h0};
            ks_new[127:96] = kw_q[255:224] ^ ks_t;
            ks_new[95:64]  = kw_q[223:192] ^ ks_new[127:96];
            ks_new[63:32]  = kw_q[191:160] ^ ks_new[95:64];
            ks_new[31:0]   = kw_q[159:128] ^ ks_new[63:32];
            if (rnd_q == 4'd1) begin
                rk        = kw_q[127:0];
                kw_next   = kw_q;
                rcon_next = rcon_q;
            end else begin
                rk        = ks_new;
                kw_next   = {kw_q[127:0], ks_new};
                rcon_next = rnd_q[0] ? rcon_q : xtime(rcon_q);
            end
        end
    end else begin : g_ks128
        // Window holds the previous round key; derive the next one from it.
        always_comb begin
            ks_t = sub_word({kw_q[23:0], kw_q[31:24]}) ^ {rcon_q, 24'h0};
            ks_new[127:96] = kw_q[127:96] ^ ks_t;
            ks_new[95:64]  = kw_q[95:64] ^ ks_new[127:96];
            ks_new[63:32]  = kw_q[63:32] ^ ks_new[95:64];
            ks_new[31:0]   = kw_q[31:0] ^ ks_new[63:32];
            rk        = ks_new;
            kw_next   = ks_new;
            rcon_next = xtime(rcon_q);
        end
    end

    assign in_ready = (state_q == StIdle) & ~key_valid & rst;

    // Next-state logic for the FSM and all datapath registers.
    always_comb begin
        state_d     = state_q;
        st_d        = st_q;
        kw_d        = kw_q;
        key_d       = key_q;
        rcon_d      = rcon_q;
        rnd_d       = rnd_q;
        text_out_d  = text_out_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        unique case (state_q)
            StIdle: begin
                if (key_valid) begin
                    key_d = key;
                end else if (in_valid) begin
                    st_d    = text_in ^ key_q[KEY_BITS-1 -: 128];
                    kw_d    = key_q;
                    rcon_d  = 8'h01;
                    rnd_d   = 4'd1;
                    busy_d  = 1'b1;
                    state_d = StRound;
                end
            end
            StRound: begin
                kw_d   = kw_next;
                rcon_d = rcon_next;
                if (rnd_q == LastRnd) begin
                    st_d        = sb_shift ^ rk;
                    text_out_d  = sb_shift ^ rk;
                    out_valid_d = 1'b1;
                    rnd_d       = 4'd0;
                    state_d     = StHold;
                end else begin
                    st_d  = mixed ^ rk;
                    rnd_d = rnd_q + 4'd1;
                end
            end
            StHold: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
`ifdef AES_CIPHER_ABORT_EN
        // Abort drops the block in flight but keeps the loaded key.
        if (abort && state_q != StIdle) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
            text_out_d  = '0;
            rnd_d       = 4'd0;
            busy_d      = 1'b0;
        end
`endif
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            st_q        <= '0;
            kw_q        <= '0;
            key_q       <= '0;
            rcon_q      <= 8'h01;
            rnd_q       <= 4'd0;
            text_out_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            kw_q        <= kw_d;
            key_q       <= key_d;
            rcon_q      <= rcon_d;
            rnd_q       <= rnd_d;
            text_out_q  <= text_out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign text_out  = text_out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign rnd       = rnd_q;

endmodule

// File: tb/tb_aes_cipher_ks.sv
// Testbench for aes_cipher_ks: one AES-128 and one AES-256 instance.
// Expected ciphertexts are queued at acceptance and popped by an output monitor.
module tb_aes_cipher_ks;

    localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K256  =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] KB    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PTB   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CTB   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         rst;
    logic         kv[2];
    logic [255:0] key_s[2];
    logic         iv[2];
    logic [127:0] ti[2];
    logic         ordy[2];
    logic         ir[2];
    logic         ov[2];
    logic [127:0] to[2];
    logic         bsy[2];
    logic [3:0]   rn[2];
`ifdef AES_CIPHER_ABORT_EN
    logic         ab[2];
`endif

    int           n_chk = 0;
    int           n_fail = 0;
    logic [127:0] exp0[$];
    logic [127:0] exp1[$];
    logic [7:0]   sb[256];
    logic         rand_bp = 1'b0;

    always #5 clk = ~clk;

    aes_cipher_ks #(.KEY_BITS(128)) dut128 (
        .clk(clk), .rst(rst), .key_valid(kv[0]), .key(key_s[0][255:128]),
        .in_valid(iv[0]), .in_ready(ir[0]), .text_in(ti[0]), .out_valid(ov[0]),
        .out_ready(ordy[0]), .text_out(to[0]), .busy(bsy[0]),
`ifdef AES_CIPHER_ABORT_EN
        .abort(ab[0]),
`endif
        .rnd(rn[0])
    );

    aes_cipher_ks #(.KEY_BITS(256)) dut256 (
        .clk(clk), .rst(rst), .key_valid(kv[1]), .key(key_s[1]),
        .in_valid(iv[1]), .in_ready(ir[1]), .text_in(ti[1]), .out_valid(ov[1]),
        .out_ready(ordy[1]), .text_out(to[1]), .busy(bsy[1]),
`ifdef AES_CIPHER_ABORT_EN
        .abort(ab[1]),
`endif
        .rnd(rn[1])
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (FIPS-197 arithmetic) ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    // Key in the upper nk words of key; nk = 4 or 8.
    function automatic logic [127:0] aes_ref(input logic [255:0] key, input int nk,
                                             input logic [127:0] pt);
        logic [31:0]  w[60];
        logic [31:0]  tmp;
        logic [7:0]   s[16];
        logic [7:0]   t[16];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [127:0] res;
        int           nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            tmp = w[i - 1];
            if (i % nk == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i - nk] ^ tmp;
        end
        for (int j = 0; j < 16; j++) s[j] = pt[127 - 8 * j -: 8] ^ w[j / 4][31 - 8 * (j % 4) -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int j = 0; j < 16; j++) t[j] = sb[s[j]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) s[4 * c + row] = t[4 * ((c + row) % 4) + row];
            if (r < nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4 * c]; a1 = s[4 * c + 1]; a2 = s[4 * c + 2]; a3 = s[4 * c + 3];
                    s[4 * c]     = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4 * c + 1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4 * c + 2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4 * c + 3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int j = 0; j < 16; j++) s[j] ^= w[4 * r + j / 4][31 - 8 * (j % 4) -: 8];
        end
        for (int j = 0; j < 16; j++) res[127 - 8 * j -: 8] = s[j];
        return res;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int k, input logic [127:0] v);
        if (k == 0) exp0.push_back(v);
        else exp1.push_back(v);
    endtask

    task automatic load_key(input int k, input logic [255:0] kk);
        kv[k] = 1'b1;
        key_s[k] = kk;
        tick();
        kv[k] = 1'b0;
    endtask

    // Offer a block and hold it until accepted; returns just after the acceptance edge.
    task automatic send(input int k, input logic [127:0] pt, input logic [127:0] exp,
                        input bit push, output int waits);
        waits = 0;
        iv[k] = 1'b1;
        ti[k] = pt;
        @(negedge clk);
        while (!ir[k] && waits < 60) begin
            @(negedge clk);
            waits++;
        end
        check($sformatf("dut%0d in_ready for block", k), ir[k], 1'b1);
        if (ir[k] && push) push_exp(k, exp);
        tick();
        iv[k] = 1'b0;
    endtask

    // Cycles from the acceptance edge to out_valid; returns on a falling edge.
    task automatic wait_out(input int k, output int lat);
        lat = 0;
        @(negedge clk);
        while (!ov[k] && lat < 40) begin
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        @(negedge clk);
        while (!ir[k] && n < 80) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("dut%0d back to idle", k), ir[k], 1'b1);
        tick();
    endtask

    task automatic check_reset_outs(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s dut%0d out_valid", tag, k), ov[k], 1'b0);
            check($sformatf("%s dut%0d text_out", tag, k), to[k], '0);
            check($sformatf("%s dut%0d busy", tag, k), bsy[k], 1'b0);
            check($sformatf("%s dut%0d rnd", tag, k), rn[k], 4'd0);
        end
    endtask

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                if (ov[k] && ordy[k]) begin
                    if ((k == 0 ? exp0.size() : exp1.size()) == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL dut%0d unexpected output: got %h, expected none", k, to[k]);
                    end else if (k == 0) begin
                        check("dut128 ciphertext", to[0], exp0.pop_front());
                    end else begin
                        check("dut256 ciphertext", to[1], exp1.pop_front());
                    end
                end
            end
        end
    end

    // Random output backpressure while enabled.
    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            ordy[0] = 1'($urandom_range(0, 1));
            ordy[1] = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int           lat, w, n;
        logic [127:0] saved;
        logic [255:0] knew, kother, kr;
        logic [127:0] p;
        logic         seen;

        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end

        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            kv[k] = 1'b0; iv[k] = 1'b0; ordy[k] = 1'b1; ti[k] = '0; key_s[k] = '0;
`ifdef AES_CIPHER_ABORT_EN
            ab[k] = 1'b0;
`endif
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) check($sformatf("dut%0d in_ready in reset", k), ir[k], 1'b0);
        check_reset_outs("reset");
        tick();
        rst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) check($sformatf("dut%0d in_ready after reset", k), ir[k], 1'b1);
        tick();

        // Known-answer vectors with latency.
        load_key(0, {K128, 128'h0});
        send(0, PT, CT128, 1, w);
        wait_out(0, lat);
        check("aes128 latency", lat, 10);
        tick();
        wait_idle(0);
        load_key(1, K256);
        send(1, PT, CT256, 1, w);
        wait_out(1, lat);
        check("aes256 latency", lat, 14);
        tick();
        wait_idle(1);

        // Back-to-back under one key with output backpressure.
        load_key(0, {KB, 128'h0});
        ordy[0] = 1'b0;
        send(0, PTB, CTB, 1, w);
        iv[0] = 1'b1;
        ti[0] = PT;
        wait_out(0, lat);
        check("bp latency", lat, 10);
        check("bp first ct", to[0], CTB);
        saved = to[0];
        for (int i = 0; i < 5; i++) begin
            check("bp text_out stable", to[0], saved);
            check("bp in_ready low", ir[0], 1'b0);
            check("bp out_valid held", ov[0], 1'b1);
            check("bp busy in hold", bsy[0], 1'b1);
            @(negedge clk);
        end
        tick();
        ordy[0] = 1'b1;
        send(0, PT, aes_ref({KB, 128'h0}, 4, PT), 1, w);
        wait_idle(0);

        // Simultaneous key_valid and in_valid, then a mid-round key pulse.
        knew = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
        kother = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
        p = {$urandom(), $urandom(), $urandom(), $urandom()};
        kv[0] = 1'b1;
        key_s[0] = knew;
        iv[0] = 1'b1;
        ti[0] = p;
        @(negedge clk);
        check("in_ready low with key_valid", ir[0], 1'b0);
        tick();
        kv[0] = 1'b0;
        send(0, p, aes_ref(knew, 4, p), 1, w);
        check("accepted on next cycle", w, 0);
        repeat (3) tick();
        kv[0] = 1'b1;
        key_s[0] = kother;
        tick();
        kv[0] = 1'b0;
        wait_idle(0);
        p = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(0, p, aes_ref(knew, 4, p), 1, w);
        wait_idle(0);

        // Random keys and blocks with random backpressure.
        rand_bp = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int it = 0; it < 5; it++) begin
                kr = {$urandom(), $urandom(), $urandom(), $urandom(),
                      $urandom(), $urandom(), $urandom(), $urandom()};
                p = {$urandom(), $urandom(), $urandom(), $urandom()};
                load_key(k, kr);
                send(k, p, aes_ref(kr, (k == 0) ? 4 : 8, p), 1, w);
                wait_idle(k);
            end
        end
        rand_bp = 1'b0;
        tick();
        tick();
        ordy[0] = 1'b1;
        ordy[1] = 1'b1;
        tick();

        // Reset in the middle of a block.
        load_key(0, {K128, 128'h0});
        send(0, PT, '0, 0, w);
        n = 0;
        @(negedge clk);
        while (rn[0] != 4'd5 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("reached round 5", rn[0], 4'd5);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("in_ready low during reset", ir[0], 1'b0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check_reset_outs("mid-round reset");
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (ov[0]) seen = 1'b1;
        end
        check("no out_valid after reset", seen, 1'b0);
        tick();
        load_key(0, {K128, 128'h0});
        send(0, PT, CT128, 1, w);
        wait_idle(0);

`ifdef AES_CIPHER_ABORT_EN
        // Abort at round 3, then a block with no key reload.
        send(0, PTB, '0, 0, w);
        n = 0;
        @(negedge clk);
        while (rn[0] != 4'd2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        tick();
        check("abort at round 3", rn[0], 4'd3);
        ab[0] = 1'b1;
        tick();
        ab[0] = 1'b0;
        @(negedge clk);
        check("abort out_valid", ov[0], 1'b0);
        check("abort in_ready", ir[0], 1'b1);
        check("abort busy", bsy[0], 1'b0);
        check("abort rnd", rn[0], 4'd0);
        check("abort text_out", to[0], '0);
        seen = 1'b0;
        repeat (16) begin
            @(negedge clk);
            if (ov[0]) seen = 1'b1;
        end
        check("no out_valid after abort", seen, 1'b0);
        tick();
        send(0, PT, CT128, 1, w);
        wait_idle(0);
`endif

        repeat (5) tick();
        check("dut128 scoreboard drained", exp0.size(), 0);
        check("dut256 scoreboard drained", exp1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
